// File: rtl/charge_pkg.sv
// Shared types for the charge-node reader: strength and value codes, FSM states, share resolution.
// Pure declarations, no logic or latency; no flow control involved.
// Included by every charge_node_* file via import charge_pkg::*.
package charge_pkg;

    typedef enum logic [2:0] {
        HIGHZ  = 3'd0,
        SMALL  = 3'd1,
        MEDIUM = 3'd2,
        WEAK   = 3'd3,
        LARGE  = 3'd4,
        PULL   = 3'd5,
        STRONG = 3'd6,
        SUPPLY = 3'd7
    } strength_e;

    typedef enum logic [1:0] {
        V0 = 2'd0,
        V1 = 2'd1,
        VX = 2'd2,
        VZ = 2'd3
    } value_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHARE = 2'd1,
        ST_SENSE = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    // Pass-gate charge sharing: the larger capacitor dominates; a tie with disagreement is unknown.
    function automatic logic [1:0] share_resolve(input logic [1:0] val_a, input logic [2:0] cap_a,
                                                 input logic [1:0] val_b, input logic [2:0] cap_b);
        logic [1:0] res;
        if (cap_a > cap_b) begin
            res = val_a;
        end else if (cap_b > cap_a) begin
            res = val_b;
        end else if (val_a == val_b) begin
            res = val_a;
        end else begin
            res = VX;
        end
        return res;
    endfunction

endpackage

// File: rtl/charge_node_cell.sv
// One charge node: value register, plus an idle decay counter when CHARGE_DECAY_EN is defined.
// Load is visible one cycle after ld; decay turns val to X after DECAY_CYCLES idle cycles.
// No handshake; ld is accepted every cycle.
module charge_node_cell
    import charge_pkg::*;
#(
    parameter int DECAY_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ld,
    input  logic [1:0] ld_val,
    output logic [1:0] val
);

    logic [1:0] val_q, val_d;

`ifdef CHARGE_DECAY_EN
    localparam int CW = $clog2(DECAY_CYCLES + 1);
    localparam logic [CW-1:0] CMAX = CW'(DECAY_CYCLES);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        val_d = val_q;
        cnt_d = cnt_q;
        if (ld) begin
            val_d = ld_val;
            cnt_d = '0;
        end else if (cnt_q != CMAX) begin
            cnt_d = cnt_q + 1'b1;
            // The cycle the count saturates is the cycle the charge is lost.
            if (cnt_d == CMAX) begin
                val_d = VX;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            val_q <= VX;
            cnt_q <= '0;
        end else begin
            val_q <= val_d;
            cnt_q <= cnt_d;
        end
    end
`else
    always_comb begin
        val_d = val_q;
        if (ld) begin
            val_d = ld_val;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            val_q <= VX;
        end else begin
            val_q <= val_d;
        end
    end
`endif

    assign val = val_q;

endmodule

// File: rtl/charge_node_reader.sv
// Read-side model of a charge-node bank with optional pair charge sharing (decay: CHARGE_DECAY_EN).
// Latency: rd_vld 3 cycles after accept (SHARE, SENSE, RESP); one read per 4 cycles.
// Backpressure: rd_rdy high only in IDLE; writes are always accepted.
module charge_node_reader
    import charge_pkg::*;
#(
    parameter int                  NODES        = 4,
    parameter logic [3*NODES-1:0]  CAP_MAP      = {NODES{3'(MEDIUM)}},
    parameter int                  DECAY_CYCLES = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_vld,
    input  logic [$clog2(NODES)-1:0] wr_idx,
    input  logic [1:0]               wr_val,
    input  logic                     rd_req,
    output logic                     rd_rdy,
    input  logic [$clog2(NODES)-1:0] rd_idx,
    input  logic                     rd_share,
    output logic                     rd_vld,
    output logic [1:0]               rd_val,
    output logic [2:0]               rd_str
);

    localparam int IW = $clog2(NODES);

    state_e          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic            share_q, share_d;
    logic [1:0]      rd_val_q, rd_val_d;
    logic [2:0]      rd_str_q, rd_str_d;

    logic [1:0]      node_val [NODES];
    logic [1:0]      eff_val  [NODES];
    logic [2:0]      cap      [NODES];
    logic            ld       [NODES];
    logic [1:0]      ld_val   [NODES];

    logic [IW-1:0]   partner;
    logic            share_do;
    logic [1:0]      share_res;

    for (genvar g = 0; g < NODES; g++) begin : g_node
        assign cap[g] = CAP_MAP[3*g +: 3];

        charge_node_cell #(
            .DECAY_CYCLES(DECAY_CYCLES)
        ) u_cell (
            .clk    (clk),
            .rst    (rst),
            .ld     (ld[g]),
            .ld_val (ld_val[g]),
            .val    (node_val[g])
        );
    end

    assign partner  = idx_q ^ IW'(1);
    assign share_do = (state_q == ST_SHARE) && share_q;

    // Same-cycle writes land before share/sense, so both operate on the written value.
    always_comb begin
        for (int i = 0; i < NODES; i++) begin
            eff_val[i] = node_val[i];
            if (wr_vld && (wr_idx == IW'(i)) && (wr_val != VZ)) begin
                eff_val[i] = wr_val;
            end
        end
    end

    assign share_res = share_resolve(eff_val[idx_q], cap[idx_q], eff_val[partner], cap[partner]);

    always_comb begin
        for (int i = 0; i < NODES; i++) begin
            ld[i]     = wr_vld && (wr_idx == IW'(i)) && (wr_val != VZ);
            ld_val[i] = wr_val;
            if (share_do && ((IW'(i) == idx_q) || (IW'(i) == partner))) begin
                ld[i]     = 1'b1;
                ld_val[i] = share_res;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        share_d  = share_q;
        rd_val_d = rd_val_q;
        rd_str_d = rd_str_q;
        unique case (state_q)
            ST_IDLE: begin
                if (rd_req) begin
                    idx_d   = rd_idx;
                    share_d = rd_share;
                    state_d = ST_SHARE;
                end
            end
            ST_SHARE: state_d = ST_SENSE;
            ST_SENSE: begin
                rd_val_d = eff_val[idx_q];
                rd_str_d = cap[idx_q];
                state_d  = ST_RESP;
            end
            ST_RESP:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            share_q  <= 1'b0;
            rd_val_q <= 2'd0;
            rd_str_q <= 3'd0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            share_q  <= share_d;
            rd_val_q <= rd_val_d;
            rd_str_q <= rd_str_d;
        end
    end

    assign rd_rdy = (state_q == ST_IDLE);
    assign rd_vld = (state_q == ST_RESP);
    assign rd_val = rd_val_q;
    assign rd_str = rd_str_q;

endmodule

// File: tb/tb_charge_node_reader.sv
// Directed bench for charge_node_reader: node0=LARGE, node1=SMALL, node2/3=MEDIUM.
module tb_charge_node_reader;

    localparam int NODES = 4;
    localparam logic [11:0] CAP = 12'b010_010_001_100;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_vld;
    logic [1:0] wr_idx;
    logic [1:0] wr_val;
    logic       rd_req;
    logic       rd_rdy;
    logic [1:0] rd_idx;
    logic       rd_share;
    logic       rd_vld;
    logic [1:0] rd_val;
    logic [2:0] rd_str;

    int total = 0;
    int bad   = 0;

    charge_node_reader #(
        .NODES        (NODES),
        .CAP_MAP      (CAP),
        .DECAY_CYCLES (16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_vld   (wr_vld),
        .wr_idx   (wr_idx),
        .wr_val   (wr_val),
        .rd_req   (rd_req),
        .rd_rdy   (rd_rdy),
        .rd_idx   (rd_idx),
        .rd_share (rd_share),
        .rd_vld   (rd_vld),
        .rd_val   (rd_val),
        .rd_str   (rd_str)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [1:0] i, input logic [1:0] v);
        wr_vld = 1'b1;
        wr_idx = i;
        wr_val = v;
        tick();
        wr_vld = 1'b0;
    endtask

    // wr_at: cycle after accept (1=SHARE, 2=SENSE) to inject a write; 0 = none.
    task automatic do_read(input logic [1:0] i, input logic sh, input int wr_at,
                           input logic [1:0] wi, input logic [1:0] wv,
                           output logic [1:0] v, output logic [2:0] s, output int lat);
        rd_req   = 1'b1;
        rd_idx   = i;
        rd_share = sh;
        tick();
        rd_req = 1'b0;
        lat    = 1;
        while (!rd_vld && lat < 10) begin
            if (lat == wr_at) begin
                wr_vld = 1'b1;
                wr_idx = wi;
                wr_val = wv;
            end
            tick();
            wr_vld = 1'b0;
            lat++;
        end
        v = rd_val;
        s = rd_str;
        tick();
    endtask

    logic [1:0] v;
    logic [2:0] s;
    int         lat;

    initial begin
        rst      = 1'b1;
        wr_vld   = 1'b0;
        wr_idx   = '0;
        wr_val   = '0;
        rd_req   = 1'b0;
        rd_idx   = '0;
        rd_share = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        chk("rst_rdy", 8'(rd_rdy), 8'd1);
        chk("rst_vld", 8'(rd_vld), 8'd0);
        chk("rst_val", 8'(rd_val), 8'd0);
        chk("rst_str", 8'(rd_str), 8'd0);

        do_read(2'd2, 1'b0, 0, 2'd0, 2'd0, v, s, lat);
        chk("init_val", 8'(v), 8'd2);
        chk("init_str", 8'(s), 8'd2);
        chk("latency", 8'(lat), 8'd3);

        do_write(2'd0, 2'd1);
        do_read(2'd0, 1'b0, 0, 2'd0, 2'd0, v, s, lat);
        chk("wr_n0_val", 8'(v), 8'd1);
        chk("wr_n0_str", 8'(s), 8'd4);

        do_write(2'd3, 2'd0);
        do_read(2'd3, 1'b0, 0, 2'd0, 2'd0, v, s, lat);
        chk("wr_n3_val", 8'(v), 8'd0);
        chk("wr_n3_str", 8'(s), 8'd2);
        do_write(2'd3, 2'd3);
        do_read(2'd3, 1'b0, 0, 2'd0, 2'd0, v, s, lat);
        chk("z_ignored", 8'(v), 8'd0);

        do_write(2'd0, 2'd1);
        do_write(2'd1, 2'd0);
        do_read(2'd1, 1'b1, 0, 2'd0, 2'd0, v, s, lat);
        chk("cap_win_val", 8'(v), 8'd1);
        chk("cap_win_str", 8'(s), 8'd1);
        do_read(2'd0, 1'b0, 0, 2'd0, 2'd0, v, s, lat);
        chk("cap_n0_val", 8'(v), 8'd1);
        chk("cap_n0_str", 8'(s), 8'd4);
        do_read(2'd1, 1'b0, 0, 2'd0, 2'd0, v, s, lat);
        chk("cap_n1_wb", 8'(v), 8'd1);

        do_write(2'd0, 2'd0);
        do_write(2'd1, 2'd1);
        do_read(2'd0, 1'b1, 0, 2'd0, 2'd0, v, s, lat);
        chk("cap_win0_val", 8'(v), 8'd0);
        do_read(2'd1, 1'b0, 0, 2'd0, 2'd0, v, s, lat);
        chk("cap_win0_n1", 8'(v), 8'd0);

        do_write(2'd2, 2'd1);
        do_write(2'd3, 2'd0);
        do_read(2'd2, 1'b1, 0, 2'd0, 2'd0, v, s, lat);
        chk("eq_conf_n2", 8'(v), 8'd2);
        chk("eq_conf_str", 8'(s), 8'd2);
        do_read(2'd3, 1'b0, 0, 2'd0, 2'd0, v, s, lat);
        chk("eq_conf_n3", 8'(v), 8'd2);

        repeat (3) tick();
        chk("hold_val", 8'(rd_val), 8'd2);
        chk("hold_vld", 8'(rd_vld), 8'd0);

        do_write(2'd2, 2'd1);
        do_read(2'd2, 1'b0, 2, 2'd2, 2'd0, v, s, lat);
        chk("wr_thru", 8'(v), 8'd0);

        do_write(2'd2, 2'd1);
        do_write(2'd3, 2'd1);
        do_read(2'd2, 1'b1, 1, 2'd3, 2'd0, v, s, lat);
        chk("coll_conf", 8'(v), 8'd2);
        do_write(2'd2, 2'd1);
        do_read(2'd2, 1'b1, 1, 2'd3, 2'd1, v, s, lat);
        chk("coll_agree", 8'(v), 8'd1);
        do_read(2'd3, 1'b0, 0, 2'd0, 2'd0, v, s, lat);
        chk("coll_n3", 8'(v), 8'd1);

        do_write(2'd0, 2'd0);
        repeat (16) tick();
        do_read(2'd0, 1'b0, 0, 2'd0, 2'd0, v, s, lat);
`ifdef CHARGE_DECAY_EN
        chk("idle16_val", 8'(v), 8'd2);
`else
        chk("idle16_val", 8'(v), 8'd0);
`endif
        chk("idle16_str", 8'(s), 8'd4);

        rd_req   = 1'b1;
        rd_idx   = 2'd0;
        rd_share = 1'b0;
        tick();
        rd_req = 1'b0;
        chk("busy_rdy", 8'(rd_rdy), 8'd0);
        tick();
        chk("sense_vld", 8'(rd_vld), 8'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_vld", 8'(rd_vld), 8'd0);
        chk("abort_rdy", 8'(rd_rdy), 8'd1);
        tick();
        chk("abort_vld2", 8'(rd_vld), 8'd0);
        do_read(2'd0, 1'b0, 0, 2'd0, 2'd0, v, s, lat);
        chk("abort_reinit", 8'(v), 8'd2);
        chk("abort_lat", 8'(lat), 8'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
